// File: rtl/uart_line_loader_if.sv
// Byte-in / line-write-out bundle between the UART receiver side and the line loader.
// The byte source (master) drives rx_*; the loader (slave) drives the bram write port and status.
interface uart_line_loader_if #(
  parameter int LINE_PIXELS = 300,
  parameter int ADDR_W      = 10
) ();
  logic [7:0]             rx_data;
  logic                   rx_ready;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [LINE_PIXELS-1:0] wr_data;
  logic [ADDR_W-1:0]      line_index;
  logic                   frame_done;
  logic                   overflow;
  logic [7:0]             bad_count;

  modport master (
    output rx_data, rx_ready,
    input  wr_en, wr_addr, wr_data, line_index, frame_done, overflow, bad_count
  );

  modport slave (
    input  rx_data, rx_ready,
    output wr_en, wr_addr, wr_data, line_index, frame_done, overflow, bad_count
  );
endinterface

// File: rtl/uart_line_loader.sv
// Parses the '#' / '+' / hex text stream from uart_rx into packed line words
// and issues one bram write per committed line.
module uart_line_loader #(
  parameter int LINE_PIXELS = 300,
  parameter int LINES       = 608,
  parameter int ADDR_W      = 10
) (
  input logic               clk,
  input logic               rst,
  uart_line_loader_if.slave bus
);
  localparam int NIB   = (LINE_PIXELS + 3) / 4;
  localparam int PTR_W = $clog2(NIB + 1);

  typedef enum logic [1:0] {S_WAIT, S_DECODE, S_COMMIT} state_t;

  state_t                 state_q, state_d;
  logic                   rdy_sync_q, rdy_sync_d;
  logic                   rdy_prev_q, rdy_prev_d;
  logic                   held_q, held_d;
  logic [7:0]             byte_q, byte_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [LINE_PIXELS-1:0] pending_q, pending_d;
  logic [ADDR_W-1:0]      line_index_q, line_index_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [LINE_PIXELS-1:0] wr_data_q, wr_data_d;
  logic                   frame_done_q, frame_done_d;
  logic                   overflow_q, overflow_d;
  logic [7:0]             bad_count_q, bad_count_d;

  logic                   rdy_edge;
  logic [4:0]             hex;
  logic [4*NIB-1:0]       wide;

  // Returns {valid, nibble} for ASCII hex digits of either case.
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    logic [7:0] t;
    t = 8'h00;
    if (b >= 8'h30 && b <= 8'h39)      t = b - 8'h30;
    else if (b >= 8'h41 && b <= 8'h46) t = b - 8'h37;
    else if (b >= 8'h61 && b <= 8'h66) t = b - 8'h57;
    else                               return 5'b0_0000;
    return {1'b1, t[3:0]};
  endfunction

  assign rdy_edge = rdy_sync_q & ~rdy_prev_q;
  assign hex      = hex_decode(byte_q);

  always_comb begin
    state_d      = state_q;
    rdy_sync_d   = bus.rx_ready;
    rdy_prev_d   = rdy_sync_q;
    held_d       = held_q;
    byte_d       = byte_q;
    ptr_d        = ptr_q;
    pending_d    = pending_q;
    line_index_d = line_index_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    bad_count_d  = bad_count_q;
    wide         = '0;

    if (rdy_edge) byte_d = bus.rx_data;

    unique case (state_q)
      S_WAIT: begin
        if (rdy_edge || held_q) begin
          state_d = S_DECODE;
          held_d  = 1'b0;
        end
      end
      S_DECODE: begin
        // An edge arriving while busy is remembered and served from WAIT.
        if (rdy_edge) held_d = 1'b1;
        state_d = S_WAIT;
        if (hex[4]) begin
          if (ptr_q < PTR_W'(NIB)) begin
            wide[LINE_PIXELS-1:0]  = pending_q;
            wide[{ptr_q, 2'b00} +: 4] = hex[3:0];
            pending_d = wide[LINE_PIXELS-1:0];
            ptr_d     = ptr_q + PTR_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end else if (byte_q == 8'h2B) begin
          state_d   = S_COMMIT;
          wr_en_d   = 1'b1;
          wr_addr_d = line_index_q;
          wr_data_d = pending_q;
          pending_d = '0;
          ptr_d     = '0;
          if (line_index_q == ADDR_W'(LINES - 1)) begin
            line_index_d = '0;
            frame_done_d = 1'b1;
          end else begin
            line_index_d = line_index_q + ADDR_W'(1);
          end
        end else if (byte_q == 8'h23) begin
          line_index_d = '0;
          ptr_d        = '0;
          pending_d    = '0;
          overflow_d   = 1'b0;
        end else if (bad_count_q != 8'hFF) begin
          bad_count_d = bad_count_q + 8'd1;
        end
      end
      S_COMMIT: begin
        if (rdy_edge) held_d = 1'b1;
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_WAIT;
      rdy_sync_q   <= 1'b0;
      rdy_prev_q   <= 1'b0;
      held_q       <= 1'b0;
      byte_q       <= '0;
      ptr_q        <= '0;
      pending_q    <= '0;
      line_index_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      bad_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      rdy_sync_q   <= rdy_sync_d;
      rdy_prev_q   <= rdy_prev_d;
      held_q       <= held_d;
      byte_q       <= byte_d;
      ptr_q        <= ptr_d;
      pending_q    <= pending_d;
      line_index_q <= line_index_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      bad_count_q  <= bad_count_d;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.line_index = line_index_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;
  assign bus.bad_count  = bad_count_q;
endmodule
